// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// dnn_pkg : shared types and constants for the DNN input-loader front end
// Rev 1.0
// ============================================================================
package dnn_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2
  } loader_state_e;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;

endpackage : dnn_pkg
`default_nettype wire

// File: rtl/dnn_input_loader.sv
`default_nettype none
// ============================================================================
// dnn_input_loader : packs a valid/ready sample stream into a 4-lane vector
//                    and strobes it into the input layer for one cycle
// Rev 1.0
// ============================================================================
module dnn_input_loader
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH      = 5,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [DATA_WIDTH-1:0]      s_data,
  input  logic                              s_last,
  input  logic                              layer_busy,
  output logic signed [DATA_WIDTH-1:0]      in0,
  output logic signed [DATA_WIDTH-1:0]      in1,
  output logic signed [DATA_WIDTH-1:0]      in2,
  output logic signed [DATA_WIDTH-1:0]      in3,
  output logic                              input_ready,
  output logic        [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                              short_frame
);

  loader_state_e                             state_q, state_d;
  logic [LANE_IDX_W-1:0]                     lane_idx_q, lane_idx_d;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]      lanes_q, lanes_d;
  logic [FRAME_CNT_WIDTH-1:0]                frame_count_q, frame_count_d;
  logic                                      short_frame_q, short_frame_d;

  logic w_accept;
  logic w_frame_done;

  assign w_accept     = s_valid && (state_q == FILL);
  assign w_frame_done = (lane_idx_q == LANE_IDX_W'(NUM_LANES - 1)) || s_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      lane_idx_q    <= '0;
      lanes_q       <= '0;
      frame_count_q <= '0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_idx_q    <= lane_idx_d;
      lanes_q       <= lanes_d;
      frame_count_q <= frame_count_d;
      short_frame_q <= short_frame_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lane_idx_d    = lane_idx_q;
    lanes_d       = lanes_q;
    frame_count_d = frame_count_q;
    short_frame_d = short_frame_q;

    unique case (state_q)
      FILL: begin
        if (w_accept) begin
          // The first sample of a frame wipes the previous vector so a short
          // frame leaves zeros in its unwritten lanes.
          if (lane_idx_q == '0) begin
            lanes_d = '0;
          end
          lanes_d[lane_idx_q] = s_data;
          if (w_frame_done) begin
            if (lane_idx_q != LANE_IDX_W'(NUM_LANES - 1)) begin
              short_frame_d = 1'b1;
            end
            state_d = layer_busy ? HOLD : ISSUE;
          end else begin
            lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (!layer_busy) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d       = FILL;
        lane_idx_d    = '0;
        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
      end
      default: begin
        state_d    = FILL;
        lane_idx_d = '0;
      end
    endcase
  end

  // Handshake and strobe decode from the state register only.
  always_comb begin
    s_ready     = (state_q == FILL);
    input_ready = (state_q == ISSUE);
  end

  assign in0         = lanes_q[0];
  assign in1         = lanes_q[1];
  assign in2         = lanes_q[2];
  assign in3         = lanes_q[3];
  assign frame_count = frame_count_q;
  assign short_frame = short_frame_q;

endmodule : dnn_input_loader
`default_nettype wire

// File: tb/tb_dnn_input_loader.sv
`default_nettype none
// ============================================================================
// tb_dnn_input_loader : directed + randomized self-checking bench for the loader
// Rev 1.0
// ============================================================================
module tb_dnn_input_loader;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic signed [4:0] s_data;
  logic              s_last;
  logic              layer_busy;
  logic signed [4:0] in0, in1, in2, in3;
  logic              input_ready;
  logic [7:0]        frame_count;
  logic              short_frame;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];
  int          stb_cyc[$];
  logic        prev_ir = 1'b0;
  logic        exp_short;
  int          frm[4];

  dnn_input_loader #(
    .DATA_WIDTH      (5),
    .FRAME_CNT_WIDTH (8)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .layer_busy  (layer_busy),
    .in0         (in0),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .input_ready (input_ready),
    .frame_count (frame_count),
    .short_frame (short_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] vec4(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic chk_lanes(input string tag, input logic [19:0] exp);
    chk(tag, {12'd0, in3, in2, in1, in0}, {12'd0, exp});
  endtask

  // Strobe observer: records every issued vector and the cycle it appeared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (input_ready) begin
        got_q.push_back({in3, in2, in1, in0});
        stb_cyc.push_back(cyc);
        chk("strobe_width", 32'(prev_ir), 32'd0);
        chk("ready_excl", 32'(s_ready), 32'd0);
      end
      prev_ir = input_ready;
    end else begin
      prev_ir = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d, input logic last);
    chk("feed_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 5'(d);
    s_last  = last;
    tick();
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    stb_cyc.delete();
  endtask

  // Sends frm[0..n-1] with random idle gaps and random downstream backpressure.
  task automatic send_frame(input int n, input int gap_pct, input int busy_pct);
    int          bnd;
    logic [19:0] v;
    v = '0;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid    = 1'b0;
        s_data     = 5'($urandom);
        s_last     = 1'($urandom);
        layer_busy = ($urandom_range(99) < busy_pct);
        tick();
      end
      s_valid = 1'b1;
      s_data  = 5'(frm[k]);
      s_last  = (k == n - 1) ? ((n < 4) ? 1'b1 : 1'($urandom)) : 1'b0;
      bnd = 0;
      while (!s_ready && bnd < 50) begin
        layer_busy = ($urandom_range(99) < busy_pct);
        tick();
        bnd++;
      end
      if (!s_ready) begin
        chk("tmo_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        return;
      end
      layer_busy = ($urandom_range(99) < busy_pct);
      tick();
      v[k*5 +: 5] = 5'(frm[k]);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_q.push_back(v);
    if (n < 4) exp_short = 1'b1;
  endtask

  task automatic wait_issue(input int n);
    int bnd;
    s_valid    = 1'b0;
    layer_busy = 1'b0;
    bnd = 0;
    while (got_q.size() < n && bnd < 100) begin
      tick();
      bnd++;
    end
    chk("issue_count", 32'(got_q.size()), 32'(n));
    bnd = 0;
    while (!s_ready && bnd < 5) begin
      tick();
      bnd++;
    end
  endtask

  task automatic compare_sb(input string tag);
    chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_vec"}, {12'd0, got_q[i]}, {12'd0, exp_q[i]});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    layer_busy = 1'b0;
    exp_short  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", 32'(input_ready), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_short", 32'(short_frame), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk_lanes("rst_lanes", 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: full frame, no backpressure
    feed(3, 1'b0); feed(-2, 1'b0); feed(7, 1'b0); feed(-16, 1'b0);
    chk("t1_ir", 32'(input_ready), 32'd1);
    chk("t1_ready", 32'(s_ready), 32'd0);
    chk_lanes("t1_lanes", vec4(3, -2, 7, -16));
    s_valid = 1'b0;
    tick();
    chk("t1_ir_low", 32'(input_ready), 32'd0);
    chk("t1_fc", 32'(frame_count), 32'd1);
    chk("t1_ready2", 32'(s_ready), 32'd1);
    chk_lanes("t1_keep", vec4(3, -2, 7, -16));

    // 2: backpressure at completion, busy toggling in FILL has no effect
    feed(3, 1'b0);
    layer_busy = 1'b1;
    feed(-2, 1'b0); feed(7, 1'b0); feed(-16, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_ir_hold", 32'(input_ready), 32'd0);
      chk("t2_ready_hold", 32'(s_ready), 32'd0);
      chk_lanes("t2_frozen", vec4(3, -2, 7, -16));
      s_valid = 1'b1;
      s_data  = 5'd9;
      if (i < 5) tick();
    end
    layer_busy = 1'b0;
    tick();
    chk("t2_ir", 32'(input_ready), 32'd1);
    chk_lanes("t2_lanes", vec4(3, -2, 7, -16));
    layer_busy = 1'b1;
    s_valid    = 1'b0;
    tick();
    chk("t2_ir_low", 32'(input_ready), 32'd0);
    chk("t2_fc", 32'(frame_count), 32'd2);
    layer_busy = 1'b0;

    // 3: short frame, then a normal frame
    feed(5, 1'b0); feed(-1, 1'b1);
    chk("t3_ir", 32'(input_ready), 32'd1);
    chk_lanes("t3_lanes", vec4(5, -1, 0, 0));
    chk("t3_short", 32'(short_frame), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b1;
    tick(); tick();
    feed(1, 1'b0); feed(1, 1'b0); feed(1, 1'b0); feed(1, 1'b1);
    chk("t3_ir2", 32'(input_ready), 32'd1);
    chk_lanes("t3_lanes2", vec4(1, 1, 1, 1));
    chk("t3_short2", 32'(short_frame), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    chk("t3_fc", 32'(frame_count), 32'd4);

    // 4: back-to-back frames, s_valid held high
    begin
      int samp[80];
      int idx;
      int bnd;
      clear_sb();
      for (int i = 0; i < 80; i++) samp[i] = int'($urandom_range(31)) - 16;
      for (int f = 0; f < 20; f++)
        exp_q.push_back(vec4(samp[4*f], samp[4*f+1], samp[4*f+2], samp[4*f+3]));
      idx = 0;
      bnd = 0;
      s_last = 1'b0;
      while (idx < 80 && bnd < 200) begin
        s_valid = 1'b1;
        s_data  = 5'(samp[idx]);
        if (s_ready) begin
          tick();
          idx++;
        end else begin
          tick();
        end
        bnd++;
      end
      s_valid = 1'b0;
      tick(); tick(); tick();
      compare_sb("t4");
      for (int i = 1; i < stb_cyc.size(); i++)
        chk("t4_gap", 32'(stb_cyc[i] - stb_cyc[i-1]), 32'd5);
      chk("t4_fc", 32'(frame_count), 32'd24);
    end

    // 5: reset during ISSUE and mid-frame
    feed(2, 1'b0); feed(2, 1'b0); feed(2, 1'b0); feed(2, 1'b0);
    s_valid = 1'b0;
    chk("t5_ir_pre", 32'(input_ready), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_ir_async", 32'(input_ready), 32'd0);
    chk("t5_fc_async", 32'(frame_count), 32'd0);
    chk("t5_short_async", 32'(short_frame), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    feed(6, 1'b0); feed(6, 1'b0);
    s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_lanes("t5_lanes_rst", 20'd0);
    chk("t5_ready_rst", 32'(s_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    feed(4, 1'b0); feed(4, 1'b0); feed(4, 1'b0); feed(4, 1'b0);
    chk("t5_ir", 32'(input_ready), 32'd1);
    chk_lanes("t5_lanes", vec4(4, 4, 4, 4));
    s_valid = 1'b0;
    tick();
    chk("t5_fc", 32'(frame_count), 32'd1);

    // 6: 256 random frames with gaps and backpressure; counter wraps
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    clear_sb();
    exp_short = 1'b0;
    for (int f = 0; f < 256; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) frm[k] = int'($urandom_range(31)) - 16;
      send_frame(n, 20, 30);
      if (f == 254) begin
        wait_issue(255);
        chk("t6_fc255", 32'(frame_count), 32'd255);
      end
    end
    wait_issue(256);
    chk("t6_fc_wrap", 32'(frame_count), 32'd0);
    chk("t6_short", 32'(short_frame), 32'(exp_short));
    compare_sb("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dnn_input_loader
`default_nettype wire

// File: doc/dnn_input_loader.md
Name: dnn_input_loader

Overview:
- Transmit side of the DNN input-layer interface.
- Accepts signed samples one at a time from the host/testbench stream over a valid/ready handshake and assembles them into a 4-lane vector.
- Presents the vector on in0..in3 and pulses input_ready for exactly one cycle, which is the single-cycle capture strobe the input layer expects.
- Sits between the host stimulus stream and the input layer, at the front of both the DNN and GNN node datapaths.

Parameters:
data_width, 5, sample and lane width in bits (DNN 5, GNN node0 7)
frame_cnt_width, 8, width of the issued-frame counter (wraps)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
s_valid  input  1  host sample valid
s_ready  output  1  loader can accept a sample this cycle
s_data  input  data_width  signed sample
s_last  input  1  marks final sample of a frame (short frame allowed)
layer_busy  input  1  downstream cannot take a vector; hold it
in0..in3  output  data_width each  signed vector lanes to input layer
input_ready  output  1  one-cycle vector strobe to input layer
frame_count  output  frame_cnt_width  number of vectors issued, wraps to 0
short_frame  output  1  sticky: a frame ended via s_last before 4 samples

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset values: state=FILL, lane index=0, in0..in3=0, input_ready=0, frame_count=0, short_frame=0. s_ready is 1 immediately after reset release.
- States:
  - FILL: s_ready=1.
  - HOLD: s_ready=0.
  - ISSUE: s_ready=0.
  - s_ready is decoded from the state register only; there is no combinational path from s_valid or layer_busy.
- Accept: a sample is accepted at a rising edge when s_valid && s_ready.
  - The k-th accepted sample of a frame (k=0..3) is written to lane k; in0 is the first sample.
  - Accepting k=0 also clears lanes 1..3 to 0 in the same edge.
- Vector completion: the vector is complete on accepting k=3, or on accepting any k<3 with s_last=1. For k<3 the unwritten lanes stay 0 and short_frame is set to 1.
  - s_last on k=3 is normal.
  - s_last is ignored when no sample is accepted.
- Completion edge:
  - If layer_busy=0, go to ISSUE and register input_ready=1.
  - Otherwise go to HOLD.
- HOLD: at each edge where layer_busy=0, go to ISSUE with input_ready=1. Lanes stay frozen for the whole of HOLD.
- ISSUE (one cycle only):
  - input_ready=1 and lanes are stable.
  - At the next edge: input_ready=0, frame_count+1 (wraps modulo 2^frame_cnt_width), lane index=0, state=FILL.
  - Lanes keep their values until the next k=0 accept.
- Timing:
  - Latency from the 4th-sample accept edge to input_ready high is one cycle when layer_busy=0.
  - Maximum throughput is one vector per 5 cycles.
- Arithmetic: samples are passed through bit-exact; there is no sign extension or saturation.
- Boundary conditions:
  - layer_busy changes during FILL: no effect.
  - layer_busy rising while in ISSUE: no effect; the strobe is already committed.
  - s_valid=1 in HOLD or ISSUE: not accepted; the host must hold the sample.
  - rst_n low mid-frame or in HOLD/ISSUE: immediate return to reset values and the partial vector is discarded. input_ready drops asynchronously.
- short_frame clears only on reset.

Decomposition:
- Shared package (dnn_pkg): loader state enum {FILL, HOLD, ISSUE}, NUM_LANES=4, and the lane index width constant (2).
- Single module; no sub-module is warranted. The lane register file and control FSM live in one always_ff plus one decode block.

Test Plan:
1. Reset, then stream 3,-2,7,-16 with s_valid held high and layer_busy=0 -> s_ready low after the 4th accept; in0..in3=3,-2,7,-16; input_ready high exactly one cycle, 1 cycle after the 4th accept; frame_count=1.
2. Same stream with layer_busy=1 for 6 cycles after completion -> input_ready stays 0 and lanes stay frozen while busy; strobe fires in the cycle after busy falls; s_ready=0 throughout.
3. Short frame 5,-1 with s_last on the 2nd sample -> lanes 5,-1,0,0; input_ready pulse; short_frame=1; the next full frame 1,1,1,1 issues normally with short_frame still 1.
4. Back-to-back frames with s_valid always high -> one strobe every 5 cycles, and no sample is dropped or duplicated (scoreboard check over 20 frames).
5. rst_n asserted after 2 samples, then released, then a full frame 4,4,4,4 -> all outputs return to 0 asynchronously; the next frame lands lanes starting at in0 with frame_count=1.
6. Issue 256 frames with frame_cnt_width=8 -> frame_count wraps to 0.
